circuit_a_core: RTL and testbench

//  4-input Boolean function F(A,B,C,D) with a registered output; the glue-logic decision cell in the control path.

---
 rtl/circuit_a_pkg.sv | 13 +
 rtl/circuit_a_sop.sv | 23 ++
 rtl/circuit_a_core.sv | 36 +++
 tb/tb_circuit_a_core.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/circuit_a_pkg.sv
// rtl/circuit_a_pkg.sv - shared constants and table lookup for the circuit_a decision cell
package circuit_a_pkg;

    typedef logic [3:0] minterm_t;

    // F = sum of minterms (0,1,2,5,8,9,10); bit i holds F for minterm i
    localparam logic [15:0] CIRCUIT_A_TT = 16'h0727;

    function automatic logic sop_eval(input logic [15:0] tt, input minterm_t idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/circuit_a_sop.sv
// rtl/circuit_a_sop.sv - combinational evaluator: reduced SOP for the default table, lookup otherwise
module circuit_a_sop
    import circuit_a_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = CIRCUIT_A_TT
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f_comb
);

    generate
        if (TRUTH_TABLE == CIRCUIT_A_TT) begin : g_sop
            // B'D' + B'C' + A'C'D covers exactly m0,m1,m2,m5,m8,m9,m10
            assign f_comb = (~b & ~d) | (~b & ~c) | (~a & ~c & d);
        end else begin : g_lut
            assign f_comb = sop_eval(TRUTH_TABLE, {a, b, c, d});
        end
    endgenerate

endmodule

// File: rtl/circuit_a_core.sv
// rtl/circuit_a_core.sv - 4-input Boolean decision cell with registered and combinational outputs
module circuit_a_core
    import circuit_a_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = CIRCUIT_A_TT,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f,
    output logic f_comb
);

    circuit_a_sop #(
        .TRUTH_TABLE(TRUTH_TABLE)
    ) u_sop (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .f_comb(f_comb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f <= RESET_VAL;
        end else begin
            f <= f_comb;
        end
    end

endmodule

// File: tb/tb_circuit_a_core.sv
// tb/tb_circuit_a_core.sv - self-checking bench for circuit_a_core
module tb_circuit_a_core;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic f, f_comb, f2, f_comb2;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    logic exp_f = 1'b0;
    logic exp_f2 = 1'b0;

    // Default table written out by hand, m0..m15
    logic lit_tab [16] = '{1,1,1,0, 0,1,0,0, 1,1,1,0, 0,0,0,0};

    circuit_a_core dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .f(f), .f_comb(f_comb)
    );

    circuit_a_core #(.TRUTH_TABLE(16'h8000)) dut_and (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .f(f2), .f_comb(f_comb2)
    );

    always #50 clk = ~clk;

    function automatic logic in_minterm_list(input int idx);
        int mins [7] = '{0, 1, 2, 5, 8, 9, 10};
        foreach (mins[i]) if (mins[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic sop_expr(input logic aa, input logic bb, input logic cc, input logic dd);
        return (!bb && !dd) || (!bb && !cc) || (!aa && !cc && dd);
    endfunction

    function automatic int cur_idx();
        return {28'd0, a, b, c, d};
    endfunction

    task automatic chk(input string name, input logic act, input logic req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %b expected %b (abcd=%b%b%b%b)", name, $time, act, req, a, b, c, d);
        end
    endtask

    // Reference registered outputs: one-cycle delayed copies of the spec function
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_f  = 1'b0;
            exp_f2 = 1'b0;
        end else begin
            exp_f  = sop_expr(a, b, c, d);
            exp_f2 = (cur_idx() == 15);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_f", f, exp_f);
            chk("cmp_f_comb", f_comb, in_minterm_list(cur_idx()));
            chk("cmp_and_f", f2, exp_f2);
            chk("cmp_and_f_comb", f_comb2, cur_idx() == 15);
        end
    end

    task automatic drive(input int idx);
        {a, b, c, d} = idx[3:0];
    endtask

    task automatic apply(input int idx);
        @(negedge clk);
        #10;
        drive(idx);
        #1;
        chk($sformatf("sweep_comb_m%0d", idx), f_comb, lit_tab[idx]);
        @(posedge clk);
        #1;
        chk($sformatf("sweep_reg_m%0d", idx), f, lit_tab[idx]);
    endtask

    initial begin
        // 1: asynchronous reset without a clock edge, then first capture
        drive(0);
        #2 rst_n = 1'b0;
        #3;
        chk("reset_no_edge", f, 1'b0);
        chk("reset_comb_m0", f_comb, 1'b1);
        #15 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_first_edge", f, 1'b1);
        chk_en = 1'b1;

        // 2: full sweep, m8 included
        for (int i = 0; i < 16; i++) apply(i);
        apply(8);

        // 3: change between edges, register holds
        apply(5);
        @(negedge clk);
        #10 drive(6);
        #1;
        chk("hold_comb_falls", f_comb, 1'b0);
        chk("hold_reg_stays", f, 1'b1);
        @(posedge clk);
        #1;
        chk("hold_reg_updates", f, 1'b0);

        // 4: mid-cycle reset overrides
        apply(10);
        #20 rst_n = 1'b0;
        #1;
        chk("midreset_f", f, 1'b0);
        chk("midreset_comb", f_comb, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_release", f, 1'b1);

        // 5: the overridden-table instance
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #10 drive(i);
            #1;
            chk($sformatf("and_comb_m%0d", i), f_comb2, (i == 15) ? 1'b1 : 1'b0);
        end

        // 6: random stimulus
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            #10 drive(int'($urandom_range(15, 0)));
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
